// File: rtl/chunked_input_buffer_if.sv
// chunked_input_buffer_if: control, read-master and consumer signals of chunked_input_buffer
interface chunked_input_buffer_if #(parameter int DATA_WIDTH = 512);
  logic                  op_start;
  logic                  end_conv;
  logic [63:0]           addr_base;
  logic [31:0]           input_byte;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  valid;
  logic                  ready;
  logic                  rmst_req;
  logic                  rmst_done;
  logic [63:0]           addr_offset;
  logic [63:0]           xfer_size;
  logic                  pop_req;
  logic                  g_stall;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_data_v;
  logic                  stall;
  logic                  busy;
  logic                  done;
  modport master (
    output op_start, end_conv, addr_base, input_byte, tdata, valid, rmst_done, pop_req, g_stall,
    input  ready, rmst_req, addr_offset, xfer_size, o_data, o_data_v, stall, busy, done
  );
  modport slave (
    input  op_start, end_conv, addr_base, input_byte, tdata, valid, rmst_done, pop_req, g_stall,
    output ready, rmst_req, addr_offset, xfer_size, o_data, o_data_v, stall, busy, done
  );
endinterface

// File: rtl/chunked_input_buffer.sv
// chunked_input_buffer: 4 KB-safe burst requester feeding a show-ahead FIFO; define IBUF_BYPASS_EN for same-cycle empty-FIFO bypass
module chunked_input_buffer #(
  parameter int DATA_WIDTH      = 512,
  parameter int FIFO_ADDR_WIDTH = 7,
  parameter int BURST_BEATS     = 64
) (
  input logic clk,
  input logic rst,
  chunked_input_buffer_if.slave bus
);
  localparam int DW_BYTE = DATA_WIDTH / 8;
  localparam int LB      = $clog2(DW_BYTE);
  localparam int DEPTH   = 2 ** FIFO_ADDR_WIDTH;
  localparam int CW      = FIFO_ADDR_WIDTH + 1;
  typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT_DONE, FLUSH} state_t;
  state_t state;
  logic [63:0] cur_addr;
  logic [33:0] rem_beats, rx_beats, burst_r, rem_calc, page_beats, burst_a, burst_c, rx_nxt;
  logic        pend;
  logic [DATA_WIDTH-1:0]      mem [DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]              cnt, free_slots;
  logic full, empty, push, pop, clear;
  assign rem_calc   = ({2'b0, bus.input_byte} + 34'(bus.addr_base[LB-1:0]) + 34'(DW_BYTE - 1)) >> LB;
  assign page_beats = (34'd4096 - {22'd0, cur_addr[11:0]}) >> LB;
  assign burst_a    = rem_beats < 34'(BURST_BEATS) ? rem_beats : 34'(BURST_BEATS);
  assign burst_c    = page_beats < burst_a ? page_beats : burst_a;
  assign full       = cnt == CW'(DEPTH);
  assign empty      = cnt == '0;
  assign free_slots = CW'(DEPTH) - cnt;
  assign bus.busy   = state != IDLE;
  assign bus.ready  = bus.busy & (state != FLUSH) & !full & (rx_beats != '0);
  assign push       = bus.valid & bus.ready;
  assign pop        = bus.pop_req & !bus.g_stall & !bus.stall;
  assign bus.o_data_v = pop;
  assign rx_nxt     = rx_beats - 34'(push);
  assign clear      = (state == FLUSH) | (bus.busy & bus.end_conv);
`ifdef IBUF_BYPASS_EN
  assign bus.o_data = empty ? bus.tdata : mem[rd_ptr];
  assign bus.stall  = empty & !push;
`else
  assign bus.o_data = mem[rd_ptr];
  assign bus.stall  = empty;
`endif
  // FIFO storage, written on every accepted beat
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= bus.tdata;
  // FIFO pointers and occupancy; flushing empties it every cycle
  always_ff @(posedge clk)
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_ADDR_WIDTH'(1);
      if (pop) rd_ptr <= rd_ptr + FIFO_ADDR_WIDTH'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  // request sequencer: splits the transfer into page-safe bursts that fit the FIFO
  always_ff @(posedge clk)
    if (rst) begin
      state           <= IDLE;
      cur_addr        <= '0;
      rem_beats       <= '0;
      rx_beats        <= '0;
      burst_r         <= '0;
      pend            <= 1'b0;
      bus.rmst_req    <= 1'b0;
      bus.addr_offset <= '0;
      bus.xfer_size   <= '0;
      bus.done        <= 1'b0;
    end else begin
      bus.done     <= 1'b0;
      bus.rmst_req <= 1'b0;
      if (push) rx_beats <= rx_nxt;
      if (bus.busy && bus.end_conv) state <= FLUSH;
      else case (state)
        IDLE: if (bus.op_start && !bus.end_conv) begin
          cur_addr  <= {bus.addr_base[63:LB], LB'(0)};
          rem_beats <= rem_calc;
          rx_beats  <= rem_calc;
          state     <= rem_calc == '0 ? IDLE : CHECK;
          bus.done  <= rem_calc == '0;
        end
        CHECK: if (34'(free_slots) >= burst_c) begin
          state           <= ISSUE;
          bus.rmst_req    <= 1'b1;
          bus.addr_offset <= cur_addr;
          bus.xfer_size   <= 64'(burst_c) << LB;
          burst_r         <= burst_c;
          pend            <= 1'b1;
        end
        ISSUE: state <= WAIT_DONE;
        WAIT_DONE: if (pend && bus.rmst_done) begin
          cur_addr  <= cur_addr + (64'(burst_r) << LB);
          rem_beats <= rem_beats - burst_r;
          pend      <= 1'b0;
          if (rem_beats != burst_r) state <= CHECK;
          else if (rx_nxt == '0) begin
            state    <= IDLE;
            bus.done <= 1'b1;
          end
        end else if (!pend && rx_nxt == '0) begin
          state    <= IDLE;
          bus.done <= 1'b1;
        end
        FLUSH: if (!pend || bus.rmst_done) begin
          state <= IDLE;
          pend  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_chunked_input_buffer.sv
// tb_chunked_input_buffer: table-driven transfers plus directed backpressure, flush, reset and bypass sequences
`timescale 1ns/1ps
module tb_chunked_input_buffer;
  localparam int DW = 512;
`ifdef IBUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  chunked_input_buffer_if #(.DATA_WIDTH(DW)) bus();
  chunked_input_buffer #(.DATA_WIDTH(DW), .FIFO_ADDR_WIDTH(7), .BURST_BEATS(64)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_vec = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int req_cnt = 0;
  always @(negedge clk) begin
    if (bus.done === 1'b1) done_cnt++;
    if (bus.rmst_req === 1'b1) req_cnt++;
  end
  typedef struct {
    logic [63:0] addr;
    logic [31:0] bytes;
    int          nreq;
    logic [63:0] a0, s0, a1, s1;
    int          beats;
  } vec_t;
  vec_t tbl[9];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic run_op(input vec_t v, input int idx);
    int nreq = 0, to_send = 0, seq_tx = 0, seq_rx = 0, data_bad = 0, seen = 0;
    logic outst = 1'b0;
    logic [63:0] a0 = '0, s0 = '0, a1 = '0, s1 = '0;
    @(negedge clk);
    bus.op_start = 1'b1;
    bus.addr_base = v.addr;
    bus.input_byte = v.bytes;
    for (int c = 0; c < 3000 && seen < 6; c++) begin
      @(negedge clk);
      bus.op_start = 1'b0;
      if (seen > 0) seen++;
      else if (bus.done) seen = 1;
      if (bus.rmst_req) begin
        if (nreq == 0) begin
          a0 = bus.addr_offset;
          s0 = bus.xfer_size;
        end
        a1 = bus.addr_offset;
        s1 = bus.xfer_size;
        nreq++;
        to_send = int'(bus.xfer_size / 64);
        outst = 1'b1;
      end
      bus.rmst_done = outst && to_send == 0;
      if (bus.rmst_done) outst = 1'b0;
      bus.valid = to_send > 0;
      bus.tdata = DW'(seq_tx);
      bus.pop_req = 1'b1;
      #1;
      if (bus.valid && bus.ready) begin
        to_send--;
        seq_tx++;
      end
      if (bus.o_data_v) begin
        if (bus.o_data[31:0] !== 32'(seq_rx)) data_bad++;
        seq_rx++;
      end
    end
    bus.valid = 1'b0;
    bus.pop_req = 1'b0;
    bus.rmst_done = 1'b0;
    chk($sformatf("v%0d done", idx), 64'(seen > 0), 64'd1);
    chk($sformatf("v%0d nreq", idx), 64'(nreq), 64'(v.nreq));
    chk($sformatf("v%0d first addr", idx), a0, v.a0);
    chk($sformatf("v%0d first size", idx), s0, v.s0);
    chk($sformatf("v%0d last addr", idx), a1, v.a1);
    chk($sformatf("v%0d last size", idx), s1, v.s1);
    chk($sformatf("v%0d beats pushed", idx), 64'(seq_tx), 64'(v.beats));
    chk($sformatf("v%0d beats popped", idx), 64'(seq_rx), 64'(v.beats));
    chk($sformatf("v%0d data order errors", idx), 64'(data_bad), 64'd0);
  endtask
  task automatic wait_req();
    for (int c = 0; c < 100 && !bus.rmst_req; c++) @(negedge clk);
    chk("rmst_req seen", 64'(bus.rmst_req), 64'd1);
  endtask
  task automatic push_beats(input int n, inout int seq);
    int got = 0;
    for (int c = 0; c < 500 && got < n; c++) begin
      @(negedge clk);
      bus.valid = 1'b1;
      bus.tdata = DW'(seq);
      #1;
      if (bus.ready) begin
        got++;
        seq++;
      end
    end
    @(negedge clk);
    bus.valid = 1'b0;
    chk("beats accepted", 64'(got), 64'(n));
  endtask
  task automatic pop_n(input int n, inout int rseq, inout int bad);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.pop_req = 1'b1;
      #1;
      if (!bus.o_data_v || bus.o_data[31:0] !== 32'(rseq)) bad++;
      rseq++;
    end
    @(negedge clk);
    bus.pop_req = 1'b0;
  endtask
  task automatic done_pulse();
    @(negedge clk);
    bus.rmst_done = 1'b1;
    @(negedge clk);
    bus.rmst_done = 1'b0;
  endtask
  initial begin
    int seq, rseq, bad, r0, d0;
    logic v0;
    logic [DW-1:0] dcap;
    tbl[0] = '{64'h1000, 32'd8192,  2, 64'h1000, 64'd4096, 64'h2000, 64'd4096, 128};
    tbl[1] = '{64'h0FC0, 32'd128,   2, 64'h0FC0, 64'd64,   64'h1000, 64'd64,   2};
    tbl[2] = '{64'h0,    32'd0,     0, 64'h0,    64'd0,    64'h0,    64'd0,    0};
    tbl[3] = '{64'h10,   32'd64,    1, 64'h0,    64'd128,  64'h0,    64'd128,  2};
    tbl[4] = '{64'h0F00, 32'd1,     1, 64'h0F00, 64'd64,   64'h0F00, 64'd64,   1};
    tbl[5] = '{64'h0E00, 32'd1024,  2, 64'h0E00, 64'd512,  64'h1000, 64'd512,  16};
    tbl[6] = '{64'h0,    32'd16384, 4, 64'h0,    64'd4096, 64'h3000, 64'd4096, 256};
    tbl[7] = '{64'h3F,   32'd1,     1, 64'h0,    64'd64,   64'h0,    64'd64,   1};
    tbl[8] = '{64'h3F,   32'd2,     1, 64'h0,    64'd128,  64'h0,    64'd128,  2};
    bus.op_start = 0; bus.end_conv = 0; bus.addr_base = 0; bus.input_byte = 0;
    bus.tdata = 0; bus.valid = 0; bus.rmst_done = 0; bus.pop_req = 0; bus.g_stall = 0;
    repeat (3) @(negedge clk);
    bus.pop_req = 1'b1;
    #1;
    chk("rst busy", 64'(bus.busy), 0);
    chk("rst ready", 64'(bus.ready), 0);
    chk("rst rmst_req", 64'(bus.rmst_req), 0);
    chk("rst addr_offset", bus.addr_offset, 0);
    chk("rst xfer_size", bus.xfer_size, 0);
    chk("rst o_data_v", 64'(bus.o_data_v), 0);
    chk("rst done", 64'(bus.done), 0);
    chk("rst stall", 64'(bus.stall), 1);
    bus.pop_req = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 9; i++) run_op(tbl[i], i);
    // backpressure: three 64-beat bursts, no pops until the third is withheld
    d0 = done_cnt;
    seq = 0; rseq = 0; bad = 0;
    @(negedge clk);
    bus.op_start = 1'b1; bus.addr_base = 0; bus.input_byte = 32'd12288;
    @(negedge clk);
    bus.op_start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      wait_req();
      push_beats(64, seq);
      done_pulse();
    end
    r0 = req_cnt;
    bus.valid = 1'b1; bus.pop_req = 1'b1; bus.g_stall = 1'b1;
    #1;
    chk("full ready", 64'(bus.ready), 0);
    chk("full stall", 64'(bus.stall), 0);
    chk("g_stall blocks pop", 64'(bus.o_data_v), 0);
    bus.valid = 1'b0; bus.pop_req = 1'b0; bus.g_stall = 1'b0;
    repeat (10) @(negedge clk);
    chk("withheld at 128", 64'(req_cnt), 64'(r0));
    chk("busy in check", 64'(bus.busy), 1);
    pop_n(28, rseq, bad);
    repeat (10) @(negedge clk);
    chk("withheld at 100", 64'(req_cnt), 64'(r0));
    pop_n(35, rseq, bad);
    repeat (5) @(negedge clk);
    chk("withheld at 65", 64'(req_cnt), 64'(r0));
    pop_n(1, rseq, bad);
    for (int c = 0; c < 4 && req_cnt == r0; c++) @(negedge clk);
    chk("issued at 64 free", 64'(req_cnt), 64'(r0 + 1));
    chk("third addr", bus.addr_offset, 64'h2000);
    chk("third size", bus.xfer_size, 64'd4096);
    chk("pop data errors", 64'(bad), 0);
    // abort while waiting for the third burst to complete
    push_beats(10, seq);
    @(negedge clk);
    bus.end_conv = 1'b1;
    @(negedge clk);
    bus.end_conv = 1'b0; bus.pop_req = 1'b1; bus.valid = 1'b1;
    #1;
    chk("flush stall", 64'(bus.stall), 1);
    chk("flush ready", 64'(bus.ready), 0);
    chk("flush o_data_v", 64'(bus.o_data_v), 0);
    chk("flush busy", 64'(bus.busy), 1);
    bus.pop_req = 1'b0; bus.valid = 1'b0;
    r0 = req_cnt;
    repeat (5) @(negedge clk);
    chk("flush waits rmst_done", 64'(bus.busy), 1);
    chk("flush no rmst_req", 64'(req_cnt), 64'(r0));
    done_pulse();
    #1;
    chk("flush to idle", 64'(bus.busy), 0);
    repeat (3) @(negedge clk);
    chk("flush no done", 64'(done_cnt), 64'(d0));
    // reset mid-operation abandons everything
    seq = 0;
    @(negedge clk);
    bus.op_start = 1'b1; bus.addr_base = 0; bus.input_byte = 32'd256;
    @(negedge clk);
    bus.op_start = 1'b0;
    wait_req();
    push_beats(2, seq);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst busy", 64'(bus.busy), 0);
    chk("midrst stall", 64'(bus.stall), 1);
    chk("midrst xfer_size", bus.xfer_size, 0);
    done_pulse();
    repeat (3) @(negedge clk);
    chk("late rmst_done busy", 64'(bus.busy), 0);
    chk("midrst no done", 64'(done_cnt), 64'(d0));
    // end_conv beats a same-cycle op_start
    @(negedge clk);
    bus.op_start = 1'b1; bus.end_conv = 1'b1; bus.input_byte = 32'd64;
    @(negedge clk);
    bus.op_start = 1'b0; bus.end_conv = 1'b0;
    #1;
    chk("end_conv overrides start", 64'(bus.busy), 0);
    // push into empty FIFO with a pop pending
    @(negedge clk);
    bus.op_start = 1'b1; bus.addr_base = 0; bus.input_byte = 32'd64;
    @(negedge clk);
    bus.op_start = 1'b0;
    wait_req();
    @(negedge clk);
    bus.valid = 1'b1; bus.tdata = DW'(8'hA5); bus.pop_req = 1'b1;
    #1;
    v0 = bus.o_data_v;
    dcap = bus.o_data;
    chk("empty push same-cycle pop", 64'(v0), 64'(BYP));
    @(negedge clk);
    bus.valid = 1'b0;
    #1;
    chk("empty push next-cycle pop", 64'(bus.o_data_v), 64'(!BYP));
    if (!v0) dcap = bus.o_data;
    chk("empty push data", 64'(dcap[7:0]), 64'hA5);
    bus.pop_req = 1'b0;
    d0 = done_cnt;
    done_pulse();
    for (int c = 0; c < 10 && done_cnt == d0; c++) @(negedge clk);
    chk("single beat done", 64'(done_cnt), 64'(d0 + 1));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
